// File: rtl/cpu_prog_loader.sv
// Streams instruction words into instruction memory, one write per accepted word,
// holding the CPU in reset until a complete load session finishes.
module cpu_prog_loader #(
    parameter int WIDTH  = 13,
    parameter int IWIDTH = 5
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      START,
    input  logic [WIDTH-IWIDTH-1:0]   END_ADDR,
    input  logic                      ABORT,
    input  logic                      DIN_VALID,
    input  logic [WIDTH-1:0]          DIN,
    output logic                      DIN_READY,
    output logic                      IMEM_WE,
    output logic [WIDTH-IWIDTH-1:0]   IMEM_ADDR,
    output logic [WIDTH-1:0]          IMEM_DATA,
    output logic                      CPU_RST,
    output logic                      BUSY,
    output logic                      DONE,
    output logic [WIDTH-1:0]          CHKSUM
);

    localparam int AW = WIDTH - IWIDTH;
    localparam logic [AW-1:0] CNT_ONE = {{(AW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FINISH} state_t;

    state_t          r_state;
    logic [AW-1:0]   r_end;
    logic [AW-1:0]   r_cnt;
    logic [AW-1:0]   r_addr;
    logic [WIDTH-1:0] r_data;
    logic [WIDTH-1:0] r_sum;
    logic            r_ready;
    logic            r_we;
    logic            r_cpu_rst;
    logic            r_busy;
    logic            r_done;
    logic            w_xfer;

    assign w_xfer = r_ready & DIN_VALID;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_state   <= S_IDLE;
            r_end     <= '0;
            r_cnt     <= '0;
            r_addr    <= '0;
            r_data    <= '0;
            r_sum     <= '0;
            r_ready   <= 1'b0;
            r_we      <= 1'b0;
            r_cpu_rst <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_we   <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (START) begin
                        r_end     <= END_ADDR;
                        r_cnt     <= '0;
                        r_sum     <= '0;
                        r_cpu_rst <= 1'b1;
                        r_ready   <= 1'b1;
                        r_busy    <= 1'b1;
                        r_state   <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    // Abort wins over a word arriving on the same edge; that word is dropped.
                    if (ABORT) begin
                        r_ready <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (w_xfer) begin
                        r_we   <= 1'b1;
                        r_addr <= r_cnt;
                        r_data <= DIN;
                        r_sum  <= r_sum ^ DIN;
                        r_cnt  <= r_cnt + CNT_ONE;
                        if (r_cnt == r_end) begin
                            r_ready <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_FINISH;
                        end
                    end
                end
                S_FINISH: begin
                    // Last write and DONE are visible now; release the CPU from the next cycle.
                    r_cpu_rst <= 1'b0;
                    r_busy    <= 1'b0;
                    r_state   <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign DIN_READY = r_ready;
    assign IMEM_WE   = r_we;
    assign IMEM_ADDR = r_addr;
    assign IMEM_DATA = r_data;
    assign CPU_RST   = r_cpu_rst;
    assign BUSY      = r_busy;
    assign DONE      = r_done;
    assign CHKSUM    = r_sum;

endmodule
